// File: rtl/pe_mac_sequencer.sv
// Command sequencer for one floating-point MAC PE: clears, seeds and steps the PE
// through one job, with an optional fixed-value post-op, and returns the accumulator.
module pe_mac_sequencer #(
  parameter int ACLEN      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [LEN_WIDTH-1:0]  job_len,
  input  logic [DATA_WIDTH-1:0] job_bias,
  input  logic                  job_post_en,
  input  logic [DATA_WIDTH-1:0] job_scale,
  input  logic [DATA_WIDTH-1:0] job_offset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_data,
  input  logic [DATA_WIDTH-1:0] op_weight,
  output logic                  pe_cmd_valid,
  output logic [ACLEN:0]        pe_cmd,
  output logic [DATA_WIDTH-1:0] pe_param_2,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic [DATA_WIDTH-1:0] pe_weight,
  input  logic                  pe_busy,
  input  logic [DATA_WIDTH-1:0] pe_mac_value,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  seq_busy
);

  localparam int CW = ACLEN + 1;
  localparam logic [CW-1:0] CMD_RESET    = CW'(3'd0);
  localparam logic [CW-1:0] CMD_TRIGGER  = CW'(3'd1);
  localparam logic [CW-1:0] CMD_MUL_VAL  = CW'(3'd2);
  localparam logic [CW-1:0] CMD_ADD_VAL  = CW'(3'd3);
  localparam logic [CW-1:0] CMD_LOAD     = CW'(3'd4);
  localparam logic [CW-1:0] CMD_CONV     = CW'(3'd5);
  localparam logic [CW-1:0] CMD_FIX_MAC  = CW'(3'd6);
  localparam logic [CW-1:0] CMD_IDLE     = CW'(3'd7);
  localparam logic [DATA_WIDTH-1:0] D_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  L_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  L_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LOAD, S_MCONV, S_FETCH, S_WAIT, S_POST_MUL,
    S_POST_ADD, S_MFIX, S_PTRIG, S_PWAIT, S_MREST, S_RES
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] bias_q, bias_d;
  logic [DATA_WIDTH-1:0] scale_q, scale_d;
  logic [DATA_WIDTH-1:0] offset_q, offset_d;
  logic                  post_en_q, post_en_d;
  logic                  seen_busy_q, seen_busy_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [CW-1:0]         cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] param_q, param_d;
  logic                  job_ready_q, job_ready_d;
  logic                  seq_busy_q, seq_busy_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  fire_s;
  logic                  wait_done_s;

  // Next state, job registers and the next value of every registered output.
  always_comb begin
    fire_s      = (state_q == S_FETCH) && op_valid;
    wait_done_s = seen_busy_q && !pe_busy;
    state_d     = state_q;
    rem_d       = rem_q;
    bias_d      = bias_q;
    scale_d     = scale_q;
    offset_d    = offset_q;
    post_en_d   = post_en_q;
    seen_busy_d = seen_busy_q;
    res_data_d  = res_data_q;
    cmd_valid_d = 1'b0;
    cmd_d       = CMD_IDLE;
    param_d     = D_ZERO;

    case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready_q) begin
          rem_d     = job_len;
          bias_d    = job_bias;
          scale_d   = job_scale;
          offset_d  = job_offset;
          post_en_d = job_post_en;
          state_d   = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR:   state_d = S_LOAD;
      S_LOAD:  state_d = S_MCONV;
      S_MCONV: begin
        if (rem_q != L_ZERO) begin
          state_d = S_FETCH;
        end else if (post_en_q) begin
          state_d = S_POST_MUL;
        end else begin
          state_d = S_RES;
        end
      end
      S_FETCH: begin
        if (fire_s) begin
          if (rem_q != L_ZERO) begin
            rem_d = rem_q - L_ONE;
          end else begin
            rem_d = L_ZERO;
          end
          seen_busy_d = 1'b0;
          state_d     = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      // Busy rises one cycle after TRIGGER; leave only once it has been seen and dropped.
      S_WAIT: begin
        seen_busy_d = seen_busy_q | pe_busy;
        if (!wait_done_s) begin
          state_d = S_WAIT;
        end else if (rem_q != L_ZERO) begin
          state_d = S_FETCH;
        end else if (post_en_q) begin
          state_d = S_POST_MUL;
        end else begin
          state_d = S_RES;
        end
      end
      S_POST_MUL: state_d = S_POST_ADD;
      S_POST_ADD: state_d = S_MFIX;
      S_MFIX:     state_d = S_PTRIG;
      S_PTRIG: begin
        seen_busy_d = 1'b0;
        state_d     = S_PWAIT;
      end
      S_PWAIT: begin
        seen_busy_d = seen_busy_q | pe_busy;
        if (wait_done_s) begin
          state_d = S_MREST;
        end else begin
          state_d = S_PWAIT;
        end
      end
      S_MREST: state_d = S_RES;
      S_RES: begin
        if (res_valid_q && res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RES;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_RES) && (state_q != S_RES)) begin
      res_data_d = pe_mac_value;
    end else begin
      res_data_d = res_data_q;
    end

    // Commands are decoded from the next state so each one appears in its own state's cycle.
    case (state_d)
      S_CLR:      begin cmd_valid_d = 1'b1; cmd_d = CMD_RESET;                     end
      S_LOAD:     begin cmd_valid_d = 1'b1; cmd_d = CMD_LOAD;    param_d = bias_q;   end
      S_MCONV:    begin cmd_valid_d = 1'b1; cmd_d = CMD_CONV;                      end
      S_POST_MUL: begin cmd_valid_d = 1'b1; cmd_d = CMD_MUL_VAL; param_d = scale_q;  end
      S_POST_ADD: begin cmd_valid_d = 1'b1; cmd_d = CMD_ADD_VAL; param_d = offset_q; end
      S_MFIX:     begin cmd_valid_d = 1'b1; cmd_d = CMD_FIX_MAC;                   end
      S_PTRIG:    begin cmd_valid_d = 1'b1; cmd_d = CMD_TRIGGER;                   end
      S_MREST:    begin cmd_valid_d = 1'b1; cmd_d = CMD_CONV;                      end
      default:    begin cmd_valid_d = 1'b0; cmd_d = CMD_IDLE;    param_d = D_ZERO;   end
    endcase

    job_ready_d = (state_d == S_IDLE);
    seq_busy_d  = (state_d != S_IDLE);
    res_valid_d = (state_d == S_RES);
  end

  // State, job and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= L_ZERO;
      bias_q      <= D_ZERO;
      scale_q     <= D_ZERO;
      offset_q    <= D_ZERO;
      post_en_q   <= 1'b0;
      seen_busy_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_IDLE;
      param_q     <= D_ZERO;
      job_ready_q <= 1'b1;
      seq_busy_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= D_ZERO;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      bias_q      <= bias_d;
      scale_q     <= scale_d;
      offset_q    <= offset_d;
      post_en_q   <= post_en_d;
      seen_busy_q <= seen_busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      param_q     <= param_d;
      job_ready_q <= job_ready_d;
      seq_busy_q  <= seq_busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // The operand TRIGGER must leave in the same cycle the pair is taken.
  assign op_ready     = fire_s;
  assign pe_cmd_valid = cmd_valid_q | fire_s;
  assign pe_cmd       = fire_s ? CMD_TRIGGER : cmd_q;
  assign pe_param_2   = param_q;
  assign pe_data      = fire_s ? op_data : D_ZERO;
  assign pe_weight    = fire_s ? op_weight : D_ZERO;
  assign job_ready    = job_ready_q;
  assign seq_busy     = seq_busy_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Bench for pe_mac_sequencer: behavioural FP PE (busy 4 cycles), result scoreboard,
// command-stream capture and one task per scenario.
module tb_pe_mac_sequencer;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 5;
  localparam int BUSY_CYC = 4;
  localparam logic [CW-1:0] C_RESET = 5'd0, C_TRIG = 5'd1, C_MUL = 5'd2, C_ADD = 5'd3,
                            C_LOAD = 5'd4, C_CONV = 5'd5, C_FIX = 5'd6, C_IDLE = 5'd7;

  logic clk_i = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0, job_post_en = 1'b0, op_valid = 1'b0, res_ready = 1'b1;
  logic [LW-1:0] job_len = '0;
  logic [DW-1:0] job_bias = '0, job_scale = '0, job_offset = '0, op_data = '0, op_weight = '0;
  logic job_ready, op_ready, pe_cmd_valid, res_valid, seq_busy, pe_busy;
  logic [CW-1:0] pe_cmd;
  logic [DW-1:0] pe_param_2, pe_data, pe_weight, pe_mac_value, res_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_viol = 0;
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] got_cmd_q[$];

  pe_mac_sequencer #(.ACLEN(4), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_bias(job_bias),
    .job_post_en(job_post_en), .job_scale(job_scale), .job_offset(job_offset),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_weight(op_weight),
    .pe_cmd_valid(pe_cmd_valid), .pe_cmd(pe_cmd), .pe_param_2(pe_param_2),
    .pe_data(pe_data), .pe_weight(pe_weight), .pe_busy(pe_busy), .pe_mac_value(pe_mac_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .seq_busy(seq_busy)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], {3'd0, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural PE: real-valued accumulator, busy for BUSY_CYC cycles after each TRIGGER.
  real acc_r = 0.0, mul_r = 0.0, add_r = 0.0, pend_r = 0.0;
  logic fix_mode = 1'b0;
  int busy_cnt = 0;
  assign pe_busy = (busy_cnt != 0);
  assign pe_mac_value = r2f(acc_r);

  always @(posedge clk_i) begin
    if (rst) begin
      acc_r <= 0.0; mul_r <= 0.0; add_r <= 0.0; fix_mode <= 1'b0; busy_cnt <= 0;
    end else begin
      if (busy_cnt == 1) acc_r <= pend_r;
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (pe_cmd_valid) begin
        got_cmd_q.push_back(pe_cmd);
        case (pe_cmd)
          C_RESET: acc_r <= 0.0;
          C_LOAD:  acc_r <= f2r(pe_param_2);
          C_MUL:   mul_r <= f2r(pe_param_2);
          C_ADD:   add_r <= f2r(pe_param_2);
          C_CONV:  fix_mode <= 1'b0;
          C_FIX:   fix_mode <= 1'b1;
          C_TRIG: begin
            pend_r <= fix_mode ? acc_r * mul_r + add_r : acc_r + f2r(pe_data) * f2r(pe_weight);
            busy_cnt <= BUSY_CYC;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic send_job(input logic [LW-1:0] len, input logic [DW-1:0] bias, input logic post,
                          input logic [DW-1:0] scale, input logic [DW-1:0] offset,
                          output int t_acc, output bit ok);
    @(negedge clk_i);
    job_len = len; job_bias = bias; job_post_en = post; job_scale = scale; job_offset = offset;
    job_valid = 1'b1;
    ok = 1'b0; t_acc = 0;
    for (int i = 0; i < 100; i++) begin
      if (job_ready) begin t_acc = cyc; ok = 1'b1; break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    job_valid = 1'b0;
  endtask

  task automatic drive_ops(input int n, input logic [DW-1:0] d, input logic [DW-1:0] w, input int gap);
    for (int k = 0; k < n; k++) begin
      op_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        #1;
        if (op_ready || (pe_cmd_valid && pe_cmd == C_TRIG)) stall_viol++;
        @(negedge clk_i);
      end
      op_valid = 1'b1; op_data = d; op_weight = w;
      for (int t = 0; t < 300; t++) begin
        #1;
        if (op_ready) begin @(posedge clk_i); break; end
        @(negedge clk_i);
      end
      @(negedge clk_i);
      op_valid = 1'b0;
    end
  endtask

  task automatic wait_res(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 500; i++) begin
      if (res_valid) begin t = cyc; ok = 1'b1; break; end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (job_ready !== 1'b1 || seq_busy !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got jr=%b busy=%b rv=%b or=%b expected 1 0 0 0", job_ready, seq_busy, res_valid, op_ready);
    end
    checks++;
    if (pe_cmd_valid !== 1'b0 || pe_cmd !== C_IDLE || pe_param_2 !== 32'h0 || pe_data !== 32'h0 ||
        pe_weight !== 32'h0 || res_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_pe: got v=%b cmd=%0d p=%h d=%h w=%h r=%h expected 0 7 0 0 0 0",
               pe_cmd_valid, pe_cmd, pe_param_2, pe_data, pe_weight, res_data);
    end
    rst = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_basic(input logic post, input int gap, input string name);
    int t_acc, t_res;
    bit ok_j, ok_r;
    logic [DW-1:0] exp;
    logic [CW-1:0] exp_cmd[$];
    got_cmd_q.delete();
    stall_viol = 0;
    if (post) begin
      exp_q.push_back(32'h40F00000);
      exp_cmd = '{C_RESET, C_LOAD, C_CONV, C_TRIG, C_TRIG, C_MUL, C_ADD, C_FIX, C_TRIG, C_CONV};
    end else begin
      exp_q.push_back(32'h41500000);
      exp_cmd = '{C_RESET, C_LOAD, C_CONV, C_TRIG, C_TRIG};
    end
    send_job(16'd2, 32'h3F800000, post, 32'h3F000000, 32'h3F800000, t_acc, ok_j);
    fork
      drive_ops(2, 32'h40000000, 32'h40400000, gap);
      wait_res(t_res, ok_r);
    join
    checks++;
    if (!ok_j || !ok_r) begin
      errors++;
      $display("FAIL %s_timeout: got accept=%b result=%b expected 1 1", name, ok_j, ok_r);
    end else begin
      exp = exp_q.pop_front();
      if (res_data !== exp) begin
        errors++;
        $display("FAIL %s_result: got %h expected %h", name, res_data, exp);
      end
      if (!post && gap == 0) begin
        checks++;
        if (t_res - t_acc != 16) begin
          errors++;
          $display("FAIL %s_latency: got %0d expected 16", name, t_res - t_acc);
        end
      end
    end
    if (gap > 0) begin
      checks++;
      if (stall_viol !== 0) begin
        errors++;
        $display("FAIL %s_stall: got %0d trigger/ready cycles with op_valid low expected 0", name, stall_viol);
      end
    end
    repeat (2) @(negedge clk_i);
    checks++;
    if (got_cmd_q.size() != exp_cmd.size()) begin
      errors++;
      $display("FAIL %s_cmd_count: got %0d expected %0d", name, got_cmd_q.size(), exp_cmd.size());
    end else begin
      for (int i = 0; i < exp_cmd.size(); i++)
        if (got_cmd_q[i] !== exp_cmd[i]) begin
          errors++;
          $display("FAIL %s_cmd[%0d]: got %0d expected %0d", name, i, got_cmd_q[i], exp_cmd[i]);
        end
    end
  endtask

  task automatic test_zero_len();
    int t_acc, t_res;
    bit ok_j, ok_r;
    logic [DW-1:0] exp;
    logic [CW-1:0] exp_cmd[$];
    got_cmd_q.delete();
    exp_q.push_back(32'h40A00000);
    exp_cmd = '{C_RESET, C_LOAD, C_CONV};
    send_job(16'd0, 32'h40A00000, 1'b0, 32'h0, 32'h0, t_acc, ok_j);
    wait_res(t_res, ok_r);
    checks++;
    if (!ok_j || !ok_r) begin
      errors++;
      $display("FAIL zero_timeout: got accept=%b result=%b expected 1 1", ok_j, ok_r);
    end else begin
      exp = exp_q.pop_front();
      if (res_data !== exp || t_res - t_acc != 4) begin
        errors++;
        $display("FAIL zero_result: got %h at +%0d expected %h at +4", res_data, t_res - t_acc, exp);
      end
    end
    repeat (2) @(negedge clk_i);
    checks++;
    if (got_cmd_q.size() != 3 || got_cmd_q[0] !== exp_cmd[0] || got_cmd_q[1] !== exp_cmd[1] ||
        got_cmd_q[2] !== exp_cmd[2]) begin
      errors++;
      $display("FAIL zero_cmds: got %0d commands expected 0,4,5", got_cmd_q.size());
    end
  endtask

  task automatic test_backpressure();
    int t_res;
    bit ok_r;
    logic [DW-1:0] held, exp;
    got_cmd_q.delete();
    res_ready = 1'b0;
    @(negedge clk_i);
    job_len = 16'd0; job_bias = 32'h40400000; job_post_en = 1'b0; job_valid = 1'b1;
    exp_q.push_back(32'h40400000);
    @(negedge clk_i);
    job_bias = 32'h40800000;
    exp_q.push_back(32'h40800000);
    wait_res(t_res, ok_r);
    held = res_data;
    checks++;
    if (!ok_r || held !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_first: got valid=%b data=%h expected 1 %h", ok_r, held, exp_q[0]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checks++;
      if (res_valid !== 1'b1 || res_data !== held || job_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got rv=%b data=%h jr=%b expected 1 %h 0", res_valid, res_data, job_ready, held);
      end
    end
    checks++;
    if (got_cmd_q.size() != 3) begin
      errors++;
      $display("FAIL bp_no_accept: got %0d commands expected 3", got_cmd_q.size());
    end
    res_ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk_i);
    res_ready = 1'b0;
    checks++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got jr=%b rv=%b expected 1 0", job_ready, res_valid);
    end
    @(negedge clk_i);
    job_valid = 1'b0;
    res_ready = 1'b1;
    wait_res(t_res, ok_r);
    checks++;
    exp = exp_q.pop_front();
    if (!ok_r || res_data !== exp) begin
      errors++;
      $display("FAIL bp_second: got valid=%b data=%h expected 1 %h", ok_r, res_data, exp);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset_mid_wait();
    int t_acc, t_res;
    bit ok_j, ok_r, seen;
    logic [DW-1:0] exp;
    send_job(16'd4, 32'h3F800000, 1'b0, 32'h0, 32'h0, t_acc, ok_j);
    op_valid = 1'b1; op_data = 32'h40000000; op_weight = 32'h40000000;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pe_busy) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    checks++;
    if (!ok_j || !seen || seq_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_reach: got accept=%b busy=%b seq_busy=%b expected 1 1 1", ok_j, seen, seq_busy);
    end
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk_i);
    rst = 1'b0;
    checks++;
    if (job_ready !== 1'b1 || seq_busy !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b0 ||
        pe_cmd_valid !== 1'b0 || pe_cmd !== C_IDLE || pe_param_2 !== 32'h0 || pe_data !== 32'h0 ||
        pe_weight !== 32'h0 || res_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait_outputs: got jr=%b sb=%b rv=%b or=%b cv=%b cmd=%0d p=%h r=%h expected 1 0 0 0 0 7 0 0",
               job_ready, seq_busy, res_valid, op_ready, pe_cmd_valid, pe_cmd, pe_param_2, res_data);
    end
    exp_q.delete();
    got_cmd_q.delete();
    exp_q.push_back(32'h3F800000);
    send_job(16'd1, 32'h00000000, 1'b0, 32'h0, 32'h0, t_acc, ok_j);
    fork
      drive_ops(1, 32'h3F800000, 32'h3F800000, 0);
      wait_res(t_res, ok_r);
    join
    checks++;
    exp = exp_q.pop_front();
    if (!ok_j || !ok_r || res_data !== exp) begin
      errors++;
      $display("FAIL rst_next_job: got valid=%b data=%h expected 1 %h", ok_r, res_data, exp);
    end
    repeat (2) @(negedge clk_i);
    checks++;
    if (got_cmd_q.size() != 4 || got_cmd_q[3] !== C_TRIG) begin
      errors++;
      $display("FAIL rst_next_cmds: got %0d commands expected 0,4,5,1", got_cmd_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic(1'b0, 0, "basic");
    test_basic(1'b1, 0, "post");
    test_zero_len();
    test_basic(1'b0, 6, "stall");
    test_backpressure();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
